// File: rtl/ganador_pkg.sv
// ganador_pkg: shared cell codes, FSM states and winning-line cell indexing
// for the tic-tac-toe style board scanner.
package ganador_pkg;

    localparam int MAXN = 8;

    typedef enum logic [1:0] {
        VACIO    = 2'b00,
        J1       = 2'b01,
        J2       = 2'b10,
        INVALIDO = 2'b11
    } tipoCelda;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } tipoEstado;

    // Entries r >= n are don't-care; lines: rows, columns, main diagonal, anti-diagonal.
    function automatic logic [MAXN-1:0][5:0] celdasLinea(input int n, input int l);
        for (int r = 0; r < MAXN; r++)
            celdasLinea[r] = 6'(l < n     ? l*n + r :
                                l < 2*n   ? r*n + l - n :
                                l == 2*n  ? r*n + r :
                                            r*n + n - 1 - r);
    endfunction

endpackage

// File: rtl/linea_check.sv
// linea_check: combinational test of one line of N cells; wins when all cells
// hold the same player code.
module linea_check
    import ganador_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0][1:0] celdas,
    output logic              gana,
    output logic [1:0]        jugador
);

    always_comb begin
        gana = (celdas[0] == J1) || (celdas[0] == J2);
        for (int i = 1; i < N; i++)
            gana = gana && (celdas[i] == celdas[0]);
        jugador = gana ? celdas[0] : VACIO;
    end

endmodule

// File: rtl/ganador_scan.sv
// ganador_scan: snapshots the board and scans one winning line per cycle.
// Draw detection is built only when GANADOR_EMPATE_EN is defined.
module ganador_scan
    import ganador_pkg::*;
#(
    parameter  int N     = 3,
    localparam int LINES = 2*N + 2,
    localparam int LW    = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*N-1:0][1:0]  tablero,
    input  logic                 inicio,
    output logic                 ocupado,
    output logic                 listo,
    output logic [1:0]           ganador,
    output logic [LW-1:0]        linea,
    output logic                 empate
);

    localparam int IW = $clog2(N*N);
    localparam logic [LW-1:0] ULTIMA = LW'(2*N + 1);

    tipoEstado               estado, sig;
    logic [N*N-1:0][1:0]     snap;
    logic [LW-1:0]           cnt;
    logic [MAXN-1:0][5:0]    idx;
    logic [N-1:0][1:0]       celdas;
    logic                    gana;
    logic [1:0]              jugador;
    logic                    captura;

    assign captura = (estado == IDLE) && inicio;
    assign ocupado = (estado == SCAN);
    assign listo   = (estado == REPORT);

    always_comb begin
        celdas = '0;
        idx = celdasLinea(N, int'(cnt));
        for (int r = 0; r < N; r++)
            celdas[r] = snap[idx[r][IW-1:0]];
    end

    linea_check #(.N(N)) uCheck (
        .celdas  (celdas),
        .gana    (gana),
        .jugador (jugador)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) estado <= IDLE;
        else     estado <= sig;

    always_comb begin
        sig = estado;
        case (estado)
            IDLE:    sig = inicio ? SCAN : IDLE;
            SCAN:    sig = (gana || cnt == ULTIMA) ? REPORT : SCAN;
            REPORT:  sig = IDLE;
            default: sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap    <= '0;
            cnt     <= '0;
            ganador <= '0;
            linea   <= '0;
        end else if (captura) begin
            snap    <= tablero;
            cnt     <= '0;
            ganador <= '0;
            linea   <= '0;
        end else if (estado == SCAN) begin
            if (gana) begin
                ganador <= jugador;
                linea   <= cnt;
            end else if (cnt != ULTIMA) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef GANADOR_EMPATE_EN
    logic lleno, lineaLlena;

    // Rows are always visited before a no-win report, so ANDing every scanned line covers the board.
    always_comb begin
        lineaLlena = 1'b1;
        for (int r = 0; r < N; r++)
            lineaLlena = lineaLlena && (celdas[r][0] ^ celdas[r][1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lleno  <= 1'b0;
            empate <= 1'b0;
        end else if (captura) begin
            lleno  <= 1'b1;
            empate <= 1'b0;
        end else if (estado == SCAN) begin
            lleno <= lleno && lineaLlena;
            if (!gana && cnt == ULTIMA)
                empate <= lleno && lineaLlena;
        end
    end
`else
    assign empate = 1'b0;
`endif

endmodule

// File: tb/tb_ganador_scan.sv
// tb_ganador_scan: directed N=3 checks of scan order, latency, hold, reset and snapshot behaviour.
module tb_ganador_scan;
    import ganador_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [8:0][1:0]  tablero;
    logic             inicio;
    logic             ocupado, listo, empate;
    logic [1:0]       ganador;
    logic [2:0]       linea;
    logic [8:0][1:0]  tab;
    int               tests = 0;
    int               fails = 0;
    int               n;

`ifdef GANADOR_EMPATE_EN
    localparam logic EMP = 1'b1;
`else
    localparam logic EMP = 1'b0;
`endif

    ganador_scan #(.N(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .tablero (tablero),
        .inicio  (inicio),
        .ocupado (ocupado),
        .listo   (listo),
        .ganador (ganador),
        .linea   (linea),
        .empate  (empate)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitListo(output int cyc);
        cyc = 0;
        while (!listo && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic scan(input string tag, input int lat, input int g, input int l, input int e);
        int c;
        tablero = tab;
        inicio  = 1'b1;
        @(posedge clk); #1;
        inicio  = 1'b0;
        chk({tag, ".busy"}, int'(ocupado), 1);
        chk({tag, ".clr"}, int'(ganador), 0);
        waitListo(c);
        chk({tag, ".lat"}, c, lat - 1);
        chk({tag, ".gan"}, int'(ganador), g);
        chk({tag, ".lin"}, int'(linea), l);
        chk({tag, ".emp"}, int'(empate), e);
        chk({tag, ".idle"}, int'(ocupado), 0);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, int'(listo), 0);
    endtask

    initial begin
        rst = 1'b1; inicio = 1'b0; tablero = '0; tab = '0;
        #12;
        chk("rst.ocu", int'(ocupado), 0);
        chk("rst.lis", int'(listo), 0);
        chk("rst.gan", int'(ganador), 0);
        chk("rst.lin", int'(linea), 0);
        chk("rst.emp", int'(empate), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        tab = '0; tab[0] = J1; tab[1] = J1; tab[2] = J1;
        scan("row0", 2, 1, 0, 0);

        tab = '0; tab[2] = J2; tab[4] = J2; tab[6] = J2;
        scan("anti", 9, 2, 7, 0);
        repeat (3) @(posedge clk); #1;
        chk("hold.gan", int'(ganador), 2);
        chk("hold.lin", int'(linea), 7);

        tab = {J1, J1, J2, J2, J2, J1, J1, J2, J1};
        scan("draw", 9, 0, 0, int'(EMP));

        tab = '0; tab[3] = INVALIDO; tab[4] = INVALIDO; tab[5] = INVALIDO;
        scan("inv", 9, 0, 0, 0);

        tab = '0; tab[6] = J1; tab[7] = J1; tab[8] = J1; tab[0] = J1; tab[3] = J1;
        scan("low", 4, 1, 2, 0);

        #2 rst = 1'b1; #1;
        chk("arst.gan", int'(ganador), 0);
        chk("arst.lin", int'(linea), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        tab = '0; tablero = tab; inicio = 1'b1;
        @(posedge clk); #1;
        inicio = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1; #1;
        chk("mid.ocu", int'(ocupado), 0);
        chk("mid.lis", int'(listo), 0);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            n += int'(listo);
        end
        chk("mid.nolisto", n, 0);

        tab = '0; tab[0] = J1; tab[1] = J1; tab[2] = J1;
        scan("after", 2, 1, 0, 0);

        tab = '0; tab[2] = J2; tab[4] = J2; tab[6] = J2;
        tablero = tab; inicio = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk); #1;
        tablero = {9{J1}};
        waitListo(n);
        chk("snap.lat", n + 3, 8);
        chk("snap.gan", int'(ganador), 2);
        chk("snap.lin", int'(linea), 7);
        @(posedge clk); #1;
        chk("snap.noq", int'(ocupado), 0);
        @(posedge clk); #1;
        chk("snap.re", int'(ocupado), 1);
        inicio = 1'b0;
        waitListo(n);
        chk("snap2.lat", n, 1);
        chk("snap2.gan", int'(ganador), 1);
        chk("snap2.lin", int'(linea), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ganador_scan.md
GANADOR_SCAN -- requirements
Module: ganador_scan

Interface
REQ-001 Parameter N, default 3: board side; legal range 3..8; board has N*N cells, row-major, cell index = r*N + c.
REQ-002 Parameter LINES, derived as 2*N+2 and not overridable: the winning lines are N rows, N columns and 2 diagonals.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 tablero  input  [N*N-1:0][1:0]  board cells: 00 empty, 01 player 1, 10 player 2, 11 invalid.
REQ-007 inicio  input  1  start request; sampled only in IDLE.
REQ-008 ocupado  output  1  high while the FSM is in SCAN.
REQ-009 listo  output  1  one-cycle pulse when the result is valid.
REQ-010 ganador  output  2  winner: 00 none, 01 player 1, 10 player 2.
REQ-011 linea  output  $clog2(LINES)  index of the winning line; 0 when there is no winner.
REQ-012 empate  output  1  draw flag.

Function
REQ-013 FSM states are IDLE, SCAN and REPORT; the state after reset is IDLE.
REQ-014 IDLE with inicio=1: capture tablero into an internal snapshot, clear the line counter to 0, go to SCAN.
- The snapshot is frozen for the whole scan; later changes on tablero are ignored.
REQ-015 SCAN: evaluate exactly one line per cycle, in index order:
- rows 0..N-1 (line i = row i);
- columns N..2N-1 (line N+j = column j);
- line 2N = main diagonal (cells r*N+r);
- line 2N+1 = anti-diagonal (cells r*N+N-1-r).
REQ-016 A line wins when all N snapshot cells are equal and equal to 01 or 10; a line containing 00 or 11 never wins.
REQ-017 First winning line found: latch ganador and linea, go to REPORT; the remaining lines are not evaluated (lowest index wins).
REQ-018 No win on line 2N+1: ganador=00, linea=0, go to REPORT.
REQ-019 REPORT lasts one cycle: listo=1, then return to IDLE.
REQ-020 Latency: with inicio accepted at edge t, a win on line L gives listo high in cycle t+2+L; no win gives listo in cycle t+2N+3.
REQ-021 inicio is ignored in SCAN and REPORT; no request is queued.
REQ-022 ganador, linea and empate are held from REPORT until the next accepted inicio, which clears them in the capture cycle.
REQ-023 ocupado=1 exactly in SCAN.
REQ-024 The line counter never wraps; exceeding 2N+1 is unreachable.

Reset
REQ-025 rst=1 asynchronously forces the following, including mid-SCAN, and aborts any scan without asserting listo:
- state IDLE;
- ocupado=0, listo=0, ganador=00, linea=0, empate=0;
- snapshot and counter cleared.
REQ-026 The first inicio after rst deasserts is accepted normally.

Configuration
REQ-027 Macro GANADOR_EMPATE_EN defined: in REPORT, empate=1 iff ganador=00 and every snapshot cell is 01 or 10.
- Full-board occupancy is computed during SCAN.
REQ-028 Macro GANADOR_EMPATE_EN undefined: the empate port remains and is tied to 0; no occupancy logic is synthesised.

Structure
REQ-029 Package ganador_pkg holds:
- a cell typedef with VACIO=00, J1=01, J2=10, INVALIDO=11;
- the FSM state enum;
- a function returning line cell indices for given N and line.
REQ-030 Sub-module linea_check is combinational: it takes N two-bit cells and returns a win flag and a player code; ganador_scan instantiates it once.

Verification (N=3)
REQ-031 Row 0 = 01,01,01, rest empty; inicio at t -> listo at t+2, ganador=01, linea=0.
REQ-032 Anti-diagonal cells 2,4,6 = 10 with no other line complete -> listo at t+9, ganador=10, linea=7.
REQ-033 Full board with no line, GANADOR_EMPATE_EN defined -> listo at t+9, ganador=00, empate=1; same board without the macro -> empate=0.
REQ-034 Row 1 all 11 -> no win; row 2 = 01s plus column 0 = 01s -> linea=2 (lowest index).
REQ-035 rst pulsed at t+3 mid-SCAN -> all outputs 0 immediately, no listo; a new inicio then gives the normal result.
REQ-036 inicio held high through SCAN plus a tablero change mid-scan -> result reflects the snapshot only; the next scan starts only from IDLE.
